// File: rtl/scan_word_fifo.sv
// scan_word_fifo: synchronous word FIFO with registered read data, registered
// flags derived from next-state count, and sticky overflow/underflow flags.
module scan_word_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned AF_MARGIN  = 2
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
   localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]      count_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   // Acceptance qualifiers and next-state occupancy.
   always_comb begin
      wr_acc    = wr_en & ~full;
      rd_acc    = rd_en & ~empty;
      count_nxt = count;
      if (wr_acc && !rd_acc) begin
         count_nxt = count + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // Storage array; only accepted writes touch it, so no reset is needed.
   always_ff @(posedge aclk) begin
      if (wr_acc && !areset) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers, count, read data and registered flags.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         data_out    <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (rd_acc) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
         end
         count       <= count_nxt;
         empty       <= (count_nxt == '0);
         full        <= (count_nxt == CNT_W'(DEPTH));
         almost_full <= (count_nxt >= CNT_W'(AF_LEVEL));
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_scan_word_fifo.sv
// Self-checking bench for scan_word_fifo: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_scan_word_fifo;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AFM   = 2;

   logic          aclk = 1'b0;
   logic          areset = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          empty, full, almost_full, overflow, underflow;
   logic [AW:0]   count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] q [$];
   logic [DW-1:0] m_dout = '0;
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;

   scan_word_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
      .aclk        (aclk),
      .areset      (areset),
      .wr_en       (wr_en),
      .data_in     (data_in),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int sz;
      sz = q.size();
      check("count",       64'(count),       64'(sz));
      check("empty",       64'(empty),       64'(sz == 0));
      check("full",        64'(full),        64'(sz == DEPTH));
      check("almost_full", 64'(almost_full), 64'(sz >= int'(DEPTH - AFM)));
      check("data_out",    64'(data_out),    64'(m_dout));
      check("overflow",    64'(overflow),    64'(m_ovf));
      check("underflow",   64'(underflow),   64'(m_unf));
   endtask

   // One clock: drive inputs, advance the model on the same edge, compare.
   task automatic step(input bit rst, input bit wr, input logic [DW-1:0] din, input bit rd);
      bit fm, em;
      areset  = rst;
      wr_en   = wr;
      data_in = din;
      rd_en   = rd;
      @(posedge aclk);
      #1;
      if (rst) begin
         q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         fm = (q.size() == DEPTH);
         em = (q.size() == 0);
         if (rd && !em) m_dout = q.pop_front();
         if (wr && !fm) q.push_back(din);
         if (wr && fm) m_ovf = 1'b1;
         if (rd && em) m_unf = 1'b1;
      end
      areset = 1'b0;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      check_all();
   endtask

   initial begin
      logic [DW-1:0] prev;
      int wb, rb;

      // Reset state
      step(1'b1, 1'b0, '0, 1'b0);

      // Scenario 1: three writes, three reads
      step(1'b0, 1'b1, 32'h11, 1'b0);
      step(1'b0, 1'b1, 32'h22, 1'b0);
      step(1'b0, 1'b1, 32'h33, 1'b0);
      check("s1_count3", 64'(count), 64'd3);
      step(1'b0, 1'b0, '0, 1'b1);
      check("s1_rd0", 64'(data_out), 64'h11);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      check("s1_rd2", 64'(data_out), 64'h33);
      check("s1_empty", 64'(empty), 64'd1);

      // Scenario 2: fill, overflow attempt, drain
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, DW'(32'h100 + i), 1'b0);
         check("s2_af", 64'(almost_full), 64'(i >= 13));
      end
      check("s2_full", 64'(full), 64'd1);
      step(1'b0, 1'b1, 32'hDEAD, 1'b0);
      check("s2_ovf", 64'(overflow), 64'd1);
      check("s2_cnt16", 64'(count), 64'd16);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         check("s2_drain", 64'(data_out), 64'(32'h100 + i));
      end

      // Scenario 3: read on empty
      prev = data_out;
      step(1'b0, 1'b0, '0, 1'b1);
      check("s3_unf", 64'(underflow), 64'd1);
      check("s3_hold", 64'(data_out), 64'(prev));

      // Scenario 4: count held at 5 with concurrent traffic across the wrap
      step(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(32'h200 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, DW'(32'h205 + i), 1'b1);
         check("s4_cnt5", 64'(count), 64'd5);
         check("s4_order", 64'(data_out), 64'(32'h200 + i));
      end

      // Scenario 5: simultaneous read/write on empty
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 32'hAA, 1'b1);
      check("s5_cnt1", 64'(count), 64'd1);
      check("s5_unf", 64'(underflow), 64'd1);
      step(1'b0, 1'b0, '0, 1'b1);
      check("s5_rd", 64'(data_out), 64'hAA);

      // Scenario 6: reset with write pending at count 9
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, DW'(32'h300 + i), 1'b0);
      step(1'b1, 1'b1, 32'h399, 1'b0);
      check("s6_cnt0", 64'(count), 64'd0);
      check("s6_empty", 64'(empty), 64'd1);
      step(1'b0, 1'b1, 32'h5A, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      check("s6_rd", 64'(data_out), 64'h5A);

      // Randomized traffic with shifting write/read bias and rare resets
      wb = 50;
      rb = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) begin
            wb = int'($urandom_range(10, 90));
            rb = int'($urandom_range(10, 90));
         end
         step($urandom_range(0, 499) == 0,
              $urandom_range(0, 99) < wb,
              $urandom,
              $urandom_range(0, 99) < rb);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
